// File: rtl/sr_latch_ctrl.sv
// Round-robin controller sharing one SR latch between NREQ requesters.
// Each grant drives a fixed s/r pulse, a quiet gap, then checks q against the expected level.
module sr_latch_ctrl #(
    parameter int NREQ      = 4,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_set,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    q,
    output logic                    s,
    output logic                    r,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [$clog2(NREQ)-1:0] gnt_id
);

    localparam int IDW  = $clog2(NREQ);
    localparam int MAXC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0]   PULSE_LD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0]   GAP_LD   = CW'(GAP_CYC - 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);
    localparam logic [IDW:0]    NREQ_W   = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0]  LAST_ID  = IDW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_GAP
    } state_t;

    state_t          r_state;
    logic            r_exp;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_gnt;
    logic [CW-1:0]   r_cnt;
    logic            r_s;
    logic            r_r;

    state_t          w_state_nxt;
    logic            w_exp_nxt;
    logic [IDW-1:0]  w_ptr_nxt;
    logic [IDW-1:0]  w_gnt_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_found;
    logic [IDW-1:0]  w_win_idx;
    logic [IDW:0]    w_sum;

    // First valid requester scanning upward from r_ptr, wrapping at NREQ.
    always_comb begin
        w_found   = 1'b0;
        w_win_idx = '0;
        w_sum     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_sum >= NREQ_W) begin
                w_sum = w_sum - NREQ_W;
            end
            if (!w_found && req_valid[w_sum[IDW-1:0]]) begin
                w_found   = 1'b1;
                w_win_idx = w_sum[IDW-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_exp_nxt   = r_exp;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = r_gnt;
        w_cnt_nxt   = r_cnt;
        req_ready   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    req_ready   = rst ? '0 : (ONE_HOT0 << w_win_idx);
                    w_state_nxt = ST_PULSE;
                    w_exp_nxt   = req_set[w_win_idx];
                    w_gnt_nxt   = w_win_idx;
                    w_ptr_nxt   = (w_win_idx == LAST_ID) ? '0 : w_win_idx + IDW'(1);
                    w_cnt_nxt   = PULSE_LD;
                end
            end
            ST_PULSE: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end else begin
                    w_cnt_nxt   = GAP_LD;
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // s and r are registered from the next state so both can never be high together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_exp   <= 1'b0;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_exp   <= w_exp_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_cnt   <= w_cnt_nxt;
            r_s     <= (w_state_nxt == ST_PULSE) &&  w_exp_nxt;
            r_r     <= (w_state_nxt == ST_PULSE) && !w_exp_nxt;
        end
    end

    assign s      = r_s;
    assign r      = r_r;
    assign busy   = (r_state != ST_IDLE);
    assign done   = (r_state == ST_GAP) && (r_cnt == '0);
    assign err    = done && (q != r_exp);
    assign gnt_id = r_gnt;

endmodule

// File: doc/sr_latch_ctrl.md
# sr_latch_ctrl

Synchronous controller that owns the single `sr_latch` instance and shares it between `NREQ` requesters. It accepts set/reset requests through a per-requester valid/ready handshake and arbitrates them round-robin. For each granted request it drives a fixed-width `s` or `r` pulse, then a recovery gap, then checks the latch output `q` against the expected value. It never drives `s` and `r` high together, so the latch can never reach its forbidden input state.

## Interface
- `NREQ`, 4: number of requesters; minimum 2.
- `PULSE_CYC`, 2: cycles `s` or `r` is held high per operation; minimum 1.
- `GAP_CYC`, 1: cycles with `s=r=0` after each pulse before `q` is checked; minimum 1.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  bit i high: requester i has a pending operation.
- `req_set`  in  NREQ  bit i: 1 = set latch, 0 = reset latch; qualified by `req_valid[i]`.
- `req_ready`  out  NREQ  one-hot grant; bit i high = request i accepted this cycle.
- `q`  in  1  latch output fed back from `sr_latch`.
- `s`  out  1  latch set input (registered).
- `r`  out  1  latch reset input (registered).
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when an operation completes.
- `err`  out  1  one-cycle pulse, coincident with `done`, when `q` does not equal the expected value.
- `gnt_id`  out  $clog2(NREQ)  index of the requester currently being serviced; holds its value after completion.

## Operation
- **States:** IDLE, PULSE, GAP.
- **IDLE:**
  - If any `req_valid` bit is high, pick winner i: the first set bit scanning upward from `ptr` with wrap-around.
  - Drive `req_ready[i]=1` combinationally in that same cycle.
  - Latch `exp <= req_set[i]`, set `gnt_id <= i`, set `ptr <= (i+1) mod NREQ`, load `cnt <= PULSE_CYC-1`, go to PULSE.
  - With no valid bits, stay in IDLE with `req_ready=0`.
- **PULSE:**
  - `s = exp`, `r = ~exp`.
  - While `cnt != 0`, decrement. At `cnt == 0`, load `cnt <= GAP_CYC-1` and go to GAP.
- **GAP:**
  - `s = r = 0`.
  - While `cnt != 0`, decrement.
  - At `cnt == 0`: `done = 1`, `err = (q != exp)`, go to IDLE.
- **Handshake:**
  - A request counts as accepted only in the cycle where `req_valid[i]` and `req_ready[i]` are both high.
  - Requesters hold `valid` and `req_set` stable until accepted.
  - `req_ready` is 0 outside IDLE.
- **Invariant:** `s & r == 0` in every cycle, including reset and parameter edge cases.
- **Simultaneous requests:** exactly one grant per IDLE cycle. Losers keep waiting, and each is served within NREQ operations (no starvation).
- **Redundant operations:** a set while `q` is already 1 (or a reset while `q` is already 0) is still fully executed.
- **Counter width:** `$clog2(max(PULSE_CYC, GAP_CYC)+1)`.

## Timing
- **Reset values:** on a cycle with `rst=1`, the next edge gives state=IDLE, `s=0`, `r=0`, `ptr=0`, `gnt_id=0`, `exp=0`, `cnt=0`. `done`, `err` and `busy` are 0. `req_ready` is 0 while `rst` is high.
- **Reset mid-operation:** `s` and `r` drop to 0 on the next edge, the operation is abandoned without `done`, and the requester must re-request.
- **Cycle budget:** accept at edge T, then:
  - `s`/`r` high for cycles T+1 … T+PULSE_CYC;
  - gap for cycles T+PULSE_CYC+1 … T+PULSE_CYC+GAP_CYC;
  - `done` in the last gap cycle;
  - next acceptance possible in cycle T+PULSE_CYC+GAP_CYC+1.
- **Throughput:** one operation per 1+PULSE_CYC+GAP_CYC cycles (4 at defaults).
- **Output timing:**
  - `busy` is high from T+1 through the `done` cycle.
  - `s`, `r`, `done`, `err` and `busy` come from registered state.
  - `req_ready` is combinational from `req_valid` and `ptr`.

## Test plan
- **Reset:** hold `rst` for 3 cycles with `req_valid=4'b1111` → `s=r=0`, `req_ready=0`, `done=0`; after release, first grant is `req_ready=4'b0001`.
- **Single set:** `req_valid=4'b0100`, `req_set=4'b0100`, healthy latch model → `req_ready[2]=1` at T, `s=1` at T+1..T+2, `s=r=0` at T+3, `done=1` and `err=0` at T+3, `gnt_id=2`, `q=1`.
- **Round-robin:** `req_valid=4'b1111` held for 4 operations → grants in order 0,1,2,3; then `req_valid=4'b1001` → grant 0 then 3; `s&r` is never 1.
- **Error check:** latch model with `q` stuck at 0, reset request then set request → first `done` has `err=0`, second has `err=1`.
- **Mid-pulse reset:** assert `rst` in cycle T+1 of a set operation → `s=0` at the next edge, no `done`, `ptr=0`.
- **Parameter sweep:** `PULSE_CYC=1`, `GAP_CYC=3` → `done` at T+4, next grant at T+5.
